// File: rtl/uart_tx_frame.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_HOLD_EN to add a one-word holding register for back-to-back frames.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Ready,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  input  logic                  Stop_Two,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Done
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    par_q, par_d;
  logic                    pen_q, pen_d;
  logic                    stop2_q, stop2_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    start_avail;
  logic                    start_frame;
  logic                    last_tick;
  logic [BIT_W-1:0]        stop_last;
  logic [DATA_WIDTH-1:0]   src_data;
  logic                    src_pen;
  logic                    src_ptype;
  logic                    src_stop2;
  logic                    src_par;

`ifdef UART_TX_HOLD_EN
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                    hold_pen_q, hold_pen_d;
  logic                    hold_ptype_q, hold_ptype_d;
  logic                    hold_stop2_q, hold_stop2_d;

  assign Ready       = !hold_full_q;
  assign accept      = Data_Valid && Ready;
  assign start_avail = hold_full_q || accept;
  assign src_data    = hold_full_q ? hold_data_q  : P_DATA;
  assign src_pen     = hold_full_q ? hold_pen_q   : Parity_Enable;
  assign src_ptype   = hold_full_q ? hold_ptype_q : Parity_Type;
  assign src_stop2   = hold_full_q ? hold_stop2_q : Stop_Two;

  // A word accepted on the same edge a frame can start goes straight to the line.
  always_comb begin
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_pen_d   = hold_pen_q;
    hold_ptype_d = hold_ptype_q;
    hold_stop2_d = hold_stop2_q;
    if (accept && !start_frame) begin
      hold_full_d  = 1'b1;
      hold_data_d  = P_DATA;
      hold_pen_d   = Parity_Enable;
      hold_ptype_d = Parity_Type;
      hold_stop2_d = Stop_Two;
    end else if (start_frame && hold_full_q) begin
      hold_full_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) hold_full_q <= 1'b0;
    else      hold_full_q <= hold_full_d;
  end

  always_ff @(posedge CLK) begin
    hold_data_q  <= hold_data_d;
    hold_pen_q   <= hold_pen_d;
    hold_ptype_q <= hold_ptype_d;
    hold_stop2_q <= hold_stop2_d;
  end
`else
  assign Ready       = (state_q == IDLE);
  assign accept      = Data_Valid && Ready;
  assign start_avail = accept;
  assign src_data    = P_DATA;
  assign src_pen     = Parity_Enable;
  assign src_ptype   = Parity_Type;
  assign src_stop2   = Stop_Two;
`endif

  assign src_par   = (^src_data) ^ src_ptype;
  assign last_tick = (pre_q == PRE_LAST);
  assign stop_last = BIT_W'(stop2_q);

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_d       = par_q;
    pen_d       = pen_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    start_frame = 1'b0;

    if (state_q != IDLE) pre_d = last_tick ? '0 : pre_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_avail) start_frame = 1'b1;
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
            tx_d    = pen_q ? par_q : 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // bit_q counts stop bits here.
        if (last_tick) begin
          if (bit_q == stop_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
            if (start_avail) start_frame = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (start_frame) begin
      state_d = START;
      pre_d   = '0;
      bit_d   = '0;
      sh_d    = src_data;
      par_d   = src_par;
      pen_d   = src_pen;
      stop2_d = src_stop2;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end

    // Done is registered, so raise it when the coming cycle is the last of the frame.
    done_d = (state_d == STOP) && (pre_d == PRE_LAST) && (bit_d == BIT_W'(stop2_d));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pre_q   <= '0;
      bit_q   <= '0;
      pen_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      pen_q   <= pen_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    sh_q  <= sh_d;
    par_q <= par_d;
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8-bit/PRESCALE=4 instance and 5-bit/PRESCALE=1 instance.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] p_data;
  logic       dv, pen, ptype, stop2;
  logic       ready, tx, busy, done;
  logic [4:0] p_data5;
  logic       dv5, pen5, ptype5, stop25;
  logic       ready5, tx5, busy5, done5;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] cap_obs [1:100];

`ifdef UART_TX_HOLD_EN
  localparam logic RDY_BUSY = 1'b1;
`else
  localparam logic RDY_BUSY = 1'b0;
`endif

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4)) u8 (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data), .Data_Valid(dv), .Ready(ready),
    .Parity_Enable(pen), .Parity_Type(ptype), .Stop_Two(stop2),
    .TX_OUT(tx), .Busy(busy), .Done(done)
  );

  uart_tx_frame #(.DATA_WIDTH(5), .PRESCALE(1)) u5 (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data5), .Data_Valid(dv5), .Ready(ready5),
    .Parity_Enable(pen5), .Parity_Type(ptype5), .Stop_Two(stop25),
    .TX_OUT(tx5), .Busy(busy5), .Done(done5)
  );

  task automatic start8(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    @(negedge clk);
    p_data = d; pen = pe; ptype = pt; stop2 = s2; dv = 1'b1;
  endtask

  // Records {TX_OUT,Busy,Done,Ready} at clocks 1..n after acceptance; optional one-cycle Data_Valid pulse.
  task automatic capture(input int n, input int pulse_at, input logic [7:0] pdata);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_obs[k] = {tx, busy, done, ready};
      dv = 1'b0;
      if (k == pulse_at) begin
        p_data = pdata;
        dv = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] o8, o5;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o8 = {tx, busy, done, ready};
    o5 = {tx5, busy5, done5, ready5};
    n_cmp++;
    if (o8 !== 4'b1001) begin n_bad++; $display("FAIL reset_u8: got %b want 1001", o8); end
    n_cmp++;
    if (o5 !== 4'b1001) begin n_bad++; $display("FAIL reset_u5: got %b want 1001", o5); end
    rst_n = 1'b1;
    @(negedge clk);
    o8 = {tx, busy, done, ready};
    n_cmp++;
    if (o8 !== 4'b1001) begin n_bad++; $display("FAIL idle_after_reset: got %b want 1001", o8); end
  endtask

  task automatic test_basic;
    logic [9:0] fr;
    logic [3:0] exp;
    fr = {1'b1, 8'hA5, 1'b0};
    start8(8'hA5, 1'b0, 1'b0, 1'b0);
    capture(42, 0, 8'h00);
    for (int k = 1; k <= 42; k++) begin
      exp = (k <= 40) ? {fr[(k-1)/4], 1'b1, (k == 40), RDY_BUSY} : 4'b1001;
      n_cmp++;
      if (cap_obs[k] !== exp) begin
        n_bad++; $display("FAIL basic clk %0d: got %b want %b", k, cap_obs[k], exp);
      end
    end
  endtask

  task automatic test_parity;
    logic [11:0] fr;
    logic [3:0]  exp;
    int          f;
    for (int c = 0; c < 2; c++) begin
      // even parity + 1 stop, then odd parity + 2 stops
      fr = (c == 0) ? {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0} : {2'b11, 1'b1, 8'hA5, 1'b0};
      f  = (c == 0) ? 44 : 48;
      start8(8'hA5, 1'b1, c[0], c[0]);
      capture(f + 2, 0, 8'h00);
      for (int k = 1; k <= f + 2; k++) begin
        exp = (k <= f) ? {fr[(k-1)/4], 1'b1, (k == f), RDY_BUSY} : 4'b1001;
        n_cmp++;
        if (cap_obs[k] !== exp) begin
          n_bad++; $display("FAIL parity%0d clk %0d: got %b want %b", c, k, cap_obs[k], exp);
        end
      end
    end
  endtask

`ifndef UART_TX_HOLD_EN
  task automatic test_ignored;
    logic [9:0] fr;
    logic [3:0] exp;
    fr = {1'b1, 8'hA5, 1'b0};
    start8(8'hA5, 1'b0, 1'b0, 1'b0);
    capture(50, 10, 8'h3C);
    for (int k = 1; k <= 50; k++) begin
      exp = (k <= 40) ? {fr[(k-1)/4], 1'b1, (k == 40), 1'b0} : 4'b1001;
      n_cmp++;
      if (cap_obs[k] !== exp) begin
        n_bad++; $display("FAIL ignored clk %0d: got %b want %b", k, cap_obs[k], exp);
      end
    end
  endtask
`endif

  task automatic test_reset_midframe;
    logic [9:0] fr;
    logic [3:0] exp, o;
    start8(8'hFA, 1'b0, 1'b0, 1'b0);
    capture(14, 0, 8'h00);
    exp = {1'b0, 1'b1, 1'b0, RDY_BUSY};
    n_cmp++;
    if (cap_obs[14] !== exp) begin n_bad++; $display("FAIL pre_abort: got %b want %b", cap_obs[14], exp); end
    rst_n = 1'b0;
    #1;
    o = {tx, busy, done, ready};
    n_cmp++;
    if (o !== 4'b1001) begin n_bad++; $display("FAIL abort_async: got %b want 1001", o); end
    @(posedge clk); #1;
    o = {tx, busy, done, ready};
    n_cmp++;
    if (o !== 4'b1001) begin n_bad++; $display("FAIL abort_held: got %b want 1001", o); end
    @(negedge clk);
    rst_n = 1'b1;
    fr = {1'b1, 8'h0F, 1'b0};
    start8(8'h0F, 1'b0, 1'b0, 1'b0);
    capture(42, 0, 8'h00);
    for (int k = 1; k <= 42; k++) begin
      exp = (k <= 40) ? {fr[(k-1)/4], 1'b1, (k == 40), RDY_BUSY} : 4'b1001;
      n_cmp++;
      if (cap_obs[k] !== exp) begin
        n_bad++; $display("FAIL after_abort clk %0d: got %b want %b", k, cap_obs[k], exp);
      end
    end
  endtask

  task automatic test_w5;
    logic [7:0] fr;
    logic [3:0] exp, o;
    fr = 8'b10100110;
    @(negedge clk);
    p_data5 = 5'b10011; pen5 = 1'b1; ptype5 = 1'b1; stop25 = 1'b0; dv5 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      o = {tx5, busy5, done5, ready5};
      dv5 = 1'b0;
      exp = (k <= 8) ? {fr[k-1], 1'b1, (k == 8), RDY_BUSY} : 4'b1001;
      n_cmp++;
      if (o !== exp) begin
        n_bad++; $display("FAIL w5 clk %0d: got %b want %b", k, o, exp);
      end
    end
  endtask

`ifdef UART_TX_HOLD_EN
  task automatic test_back_to_back;
    logic [9:0] fr0, fr1;
    logic [3:0] exp;
    logic       b;
    fr0 = {1'b1, 8'h11, 1'b0};
    fr1 = {1'b1, 8'h22, 1'b0};
    start8(8'h11, 1'b0, 1'b0, 1'b0);
    capture(82, 5, 8'h22);
    for (int k = 1; k <= 82; k++) begin
      b   = (k <= 40) ? fr0[(k-1)/4] : (k <= 80) ? fr1[(k-41)/4] : 1'b1;
      exp = {b, (k <= 80), (k == 40 || k == 80), !(k >= 6 && k <= 40)};
      n_cmp++;
      if (cap_obs[k] !== exp) begin
        n_bad++; $display("FAIL b2b clk %0d: got %b want %b", k, cap_obs[k], exp);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    p_data = '0; dv = 1'b0; pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
    p_data5 = '0; dv5 = 1'b0; pen5 = 1'b0; ptype5 = 1'b0; stop25 = 1'b0;
    test_reset();
    test_basic();
    test_parity();
`ifndef UART_TX_HOLD_EN
    test_ignored();
`endif
    test_reset_midframe();
    test_w5();
`ifdef UART_TX_HOLD_EN
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
